// File: rtl/herald_bus_master.sv
// Host-side initiator for the Herald byte-strobe accelerator bus: serialises one
// command onto WR strobes, waits out BUSY, then gathers the result with RD strobes.
module herald_bus_master #(
   parameter int STROBE_LOW = 1,
   parameter int TIMEOUT    = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_opcode,
   input  logic [23:0] cmd_a,
   input  logic [23:0] cmd_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [71:0] rsp_data,
   output logic [3:0]  rsp_len,
   output logic        rsp_err,
   output logic [7:0]  bus_data_out,
   output logic        bus_wr,
   output logic        bus_rd,
   input  logic [7:0]  bus_data_in,
   output logic [2:0]  fsm_state
);

   // Handshakes: cmd is taken on a cycle with cmd_valid && cmd_ready; rsp is
   // taken on a cycle with rsp_valid && rsp_ready, rsp_* held stable until then.

   localparam int LW = (STROBE_LOW > 1) ? $clog2(STROBE_LOW) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [LW-1:0] LO_LAST   = LW'(STROBE_LOW - 1);
   localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      WR_HI        = 3'd1,
      WR_LO        = 3'd2,
      WAIT_BUSY_HI = 3'd3,
      WAIT_BUSY_LO = 3'd4,
      RD_HI        = 3'd5,
      RD_LO        = 3'd6,
      RESP         = 3'd7
   } state_t;

   typedef struct packed {
      logic       known;
      logic [2:0] wr_left;  // operand bytes following the opcode byte
      logic [3:0] rd_len;
   } op_info_t;

   function automatic op_info_t decode(input logic [7:0] op);
      op_info_t r;
      r = '0;
      case (op)
         8'h10:                      r = '{1'b1, 3'd3, 4'd6};
         8'h11, 8'h12, 8'h20, 8'h21: r = '{1'b1, 3'd6, 4'd3};
         8'h13:                      r = '{1'b1, 3'd6, 4'd9};
         8'h23:                      r = '{1'b1, 3'd3, 4'd3};
         8'h22:                      r = '{1'b1, 3'd0, 4'd0};
         default:                    r = '0;
      endcase
      return r;
   endfunction

   state_t        state, state_n;
   op_info_t      info;
   logic [47:0]   wr_shift, wr_shift_n;
   logic [2:0]    wr_left, wr_left_n;
   logic [3:0]    rd_len, rd_len_n;
   logic [3:0]    rd_idx, rd_idx_n;
   logic [LW-1:0] lo_cnt, lo_cnt_n;
   logic [TW-1:0] wait_cnt, wait_cnt_n;
   logic [7:0]    data_out_n;
   logic [71:0]   rsp_data_n;
   logic [3:0]    rsp_len_n;
   logic          rsp_err_n;

   assign fsm_state = state;

   always_comb begin
      info       = decode(cmd_opcode);
      state_n    = state;
      wr_shift_n = wr_shift;
      wr_left_n  = wr_left;
      rd_len_n   = rd_len;
      rd_idx_n   = rd_idx;
      lo_cnt_n   = lo_cnt;
      wait_cnt_n = wait_cnt;
      data_out_n = bus_data_out;
      rsp_data_n = rsp_data;
      rsp_len_n  = rsp_len;
      rsp_err_n  = rsp_err;

      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               rsp_data_n = '0;
               rsp_len_n  = '0;
               rsp_err_n  = 1'b0;
               if (info.known) begin
                  state_n    = WR_HI;
                  data_out_n = cmd_opcode;
                  wr_shift_n = {cmd_b, cmd_a};
                  wr_left_n  = info.wr_left;
                  rd_len_n   = info.rd_len;
               end else begin
                  state_n   = RESP;
                  rsp_err_n = 1'b1;
               end
            end
         end
         WR_HI: begin
            state_n  = WR_LO;
            lo_cnt_n = '0;
         end
         WR_LO: begin
            if (lo_cnt == LO_LAST) begin
               if (wr_left != 3'd0) begin
                  state_n    = WR_HI;
                  data_out_n = wr_shift[7:0];
                  wr_shift_n = {8'h00, wr_shift[47:8]};
                  wr_left_n  = wr_left - 3'd1;
               end else begin
                  state_n    = WAIT_BUSY_HI;
                  wait_cnt_n = '0;
               end
            end else begin
               lo_cnt_n = lo_cnt + 1'b1;
            end
         end
         WAIT_BUSY_HI: begin
            if (bus_data_in[7]) begin
               state_n    = WAIT_BUSY_LO;
               wait_cnt_n = '0;
            end else if (wait_cnt == WAIT_LAST) begin
               state_n   = RESP;
               rsp_err_n = 1'b1;
            end else begin
               wait_cnt_n = wait_cnt + 1'b1;
            end
         end
         WAIT_BUSY_LO: begin
            if (!bus_data_in[7]) begin
               if (rd_len == 4'd0) begin
                  state_n = RESP;
               end else begin
                  state_n  = RD_HI;
                  rd_idx_n = '0;
               end
            end else if (wait_cnt == WAIT_LAST) begin
               state_n   = RESP;
               rsp_err_n = 1'b1;
            end else begin
               wait_cnt_n = wait_cnt + 1'b1;
            end
         end
         RD_HI: begin
            state_n  = RD_LO;
            lo_cnt_n = '0;
         end
         RD_LO: begin
            // The device presents the byte only during the first low cycle.
            if (lo_cnt == '0) begin
               for (int i = 0; i < 9; i++) begin
                  if (rd_idx == 4'(i)) rsp_data_n[8*i +: 8] = bus_data_in;
               end
            end
            if (lo_cnt == LO_LAST) begin
               if (rd_idx == rd_len - 4'd1) begin
                  state_n   = RESP;
                  rsp_len_n = rd_len;
               end else begin
                  state_n  = RD_HI;
                  rd_idx_n = rd_idx + 4'd1;
               end
            end else begin
               lo_cnt_n = lo_cnt + 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         wr_shift     <= '0;
         wr_left      <= '0;
         rd_len       <= '0;
         rd_idx       <= '0;
         lo_cnt       <= '0;
         wait_cnt     <= '0;
         bus_data_out <= '0;
         bus_wr       <= 1'b0;
         bus_rd       <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_data     <= '0;
         rsp_len      <= '0;
         rsp_err      <= 1'b0;
         cmd_ready    <= 1'b0;
      end else begin
         state        <= state_n;
         wr_shift     <= wr_shift_n;
         wr_left      <= wr_left_n;
         rd_len       <= rd_len_n;
         rd_idx       <= rd_idx_n;
         lo_cnt       <= lo_cnt_n;
         wait_cnt     <= wait_cnt_n;
         bus_data_out <= data_out_n;
         // Outputs follow the next state so they line up with the state register.
         bus_wr       <= (state_n == WR_HI);
         bus_rd       <= (state_n == RD_HI);
         rsp_valid    <= (state_n == RESP);
         rsp_data     <= rsp_data_n;
         rsp_len      <= rsp_len_n;
         rsp_err      <= rsp_err_n;
         cmd_ready    <= (state_n == IDLE);
      end
   end

endmodule

// File: tb/tb_herald_bus_master.sv
// Bench for herald_bus_master: a strobe-level Herald device model plus a
// table-driven reference for write bytes, read lengths and response latency.
module tb_herald_bus_master;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_opcode;
   logic [23:0] cmd_a;
   logic [23:0] cmd_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [71:0] rsp_data;
   logic [3:0]  rsp_len;
   logic        rsp_err;
   logic [7:0]  bus_data_out;
   logic        bus_wr;
   logic        bus_rd;
   logic [7:0]  bus_data_in = 8'h00;
   logic [2:0]  fsm_state;

   herald_bus_master #(.STROBE_LOW(1), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_len(rsp_len), .rsp_err(rsp_err),
      .bus_data_out(bus_data_out), .bus_wr(bus_wr), .bus_rd(bus_rd),
      .bus_data_in(bus_data_in), .fsm_state(fsm_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   int n_asserts = 0;
   int n_fail    = 0;

   // ---------------- device model ----------------
   int          dev_gen = 0;
   int          dev_n_wr = 0;
   int          dev_busy_delay = 0;
   int          dev_busy_len = 2;
   bit          dev_forever = 1'b0;
   logic [7:0]  dev_bytes [9];

   int unsigned cyc = 0;
   int          seen_gen = 0;
   logic [7:0]  wr_log [$];
   int unsigned wr_stamp [$];
   int          rd_count = 0;
   int          viol = 0;
   int          dev_phase = 0;
   int          dev_cd = 0;
   int          dev_bl = 0;
   logic        dev_busy = 1'b0;
   logic        prev_wr = 1'b0;
   logic        prev_rd = 1'b0;
   logic [7:0]  dev_out_next = 8'h00;

   always @(posedge clk) begin
      if (seen_gen != dev_gen) begin
         seen_gen = dev_gen;
         wr_log.delete();
         wr_stamp.delete();
         rd_count  = 0;
         viol      = 0;
         dev_phase = 0;
         dev_busy  = 1'b0;
      end
      if (bus_wr && bus_rd) viol++;
      if ((bus_wr && prev_wr) || (bus_rd && prev_rd)) viol++;
      prev_wr = bus_wr;
      prev_rd = bus_rd;
      if (bus_wr) begin
         wr_log.push_back(bus_data_out);
         wr_stamp.push_back(cyc);
         if (wr_log.size() == dev_n_wr) begin
            dev_phase = 1;
            dev_cd    = dev_busy_delay;
         end
      end
      if (dev_phase == 1) begin
         if (dev_cd == 0) begin
            dev_busy  = 1'b1;
            dev_bl    = dev_busy_len - 1;
            dev_phase = 2;
         end else begin
            dev_cd--;
         end
      end else if (dev_phase == 2) begin
         if (!dev_forever) begin
            if (dev_bl == 0) begin
               dev_busy  = 1'b0;
               dev_phase = 3;
            end else begin
               dev_bl--;
            end
         end
      end
      if (bus_rd) begin
         rd_count++;
         dev_out_next = (rd_count <= 9) ? dev_bytes[rd_count-1] : 8'hEE;
      end else begin
         dev_out_next = {dev_busy, 7'($urandom)};
      end
      cyc++;
   end

   always @(negedge clk) bus_data_in = dev_out_next;

   // ---------------- reference tables ----------------
   function automatic bit ref_known(input logic [7:0] op);
      return (op == 8'h10 || op == 8'h11 || op == 8'h12 || op == 8'h13 ||
              op == 8'h20 || op == 8'h21 || op == 8'h22 || op == 8'h23);
   endfunction

   function automatic int ref_n_wr(input logic [7:0] op);
      if (!ref_known(op)) return 0;
      if (op == 8'h22) return 1;
      if (op == 8'h10 || op == 8'h23) return 4;
      return 7;
   endfunction

   function automatic int ref_n_rd(input logic [7:0] op);
      if (!ref_known(op) || op == 8'h22) return 0;
      if (op == 8'h10) return 6;
      if (op == 8'h13) return 9;
      return 3;
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic issue_cmd(input logic [7:0] op, input logic [23:0] a, input logic [23:0] b,
                            output int unsigned n0);
      int k;
      k = 0;
      while (cmd_ready !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("cmd_ready_idle", 72'(cmd_ready), 72'(1));
      cmd_valid  = 1'b1;
      cmd_opcode = op;
      cmd_a      = a;
      cmd_b      = b;
      @(negedge clk);
      cmd_valid  = 1'b0;
      cmd_opcode = 8'($urandom);
      cmd_a      = 24'($urandom);
      cmd_b      = 24'($urandom);
      n0 = cyc;
      check("cmd_ready_drop", 72'(cmd_ready), 72'(0));
   endtask

   task automatic run_txn(input logic [7:0] op, input logic [23:0] a, input logic [23:0] b,
                          input int d, input int blen, input bit forever_busy,
                          input bit never_busy, input bit hold);
      logic [7:0]  exp_q [$];
      logic [71:0] exp_data;
      logic [3:0]  exp_len;
      int          n_wr, n_rd, k, exp_k, c, cp, bs, be, nchk;
      int unsigned n0;
      bit          known, err;

      known = ref_known(op);
      n_wr  = ref_n_wr(op);
      n_rd  = ref_n_rd(op);
      exp_q.delete();
      if (known) begin
         exp_q.push_back(op);
         if (n_wr >= 4) for (int i = 0; i < 3; i++) exp_q.push_back(a[8*i +: 8]);
         if (n_wr == 7) for (int i = 0; i < 3; i++) exp_q.push_back(b[8*i +: 8]);
      end

      // Response latency in cycles, counted from the first cycle after accept.
      if (!known) begin
         exp_k = 0;
         err   = 1'b1;
      end else if (never_busy) begin
         exp_k = 2*n_wr + TIMEOUT;
         err   = 1'b1;
      end else begin
         bs = 2*n_wr - 1 + d;
         be = bs + blen - 1;
         c  = (bs > 2*n_wr) ? bs : 2*n_wr;
         if (forever_busy) begin
            exp_k = c + 1 + TIMEOUT;
            err   = 1'b1;
         end else begin
            cp    = (be + 1 > c + 1) ? be + 1 : c + 1;
            exp_k = cp + 1 + 2*n_rd;
            err   = 1'b0;
         end
      end
      exp_data = '0;
      if (!err) for (int i = 0; i < n_rd; i++) exp_data[8*i +: 8] = dev_bytes[i];
      exp_len = err ? 4'd0 : 4'(n_rd);

      dev_n_wr       = n_wr;
      dev_busy_delay = never_busy ? 100000 : d;
      dev_busy_len   = blen;
      dev_forever    = forever_busy;
      dev_gen++;

      issue_cmd(op, a, b, n0);

      k = 0;
      while (rsp_valid !== 1'b1 && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("rsp_valid_seen", 72'(rsp_valid), 72'(1));
      check("rsp_latency", 72'(k), 72'(exp_k));
      check("rsp_err", 72'(rsp_err), 72'(err));
      check("rsp_len", 72'(rsp_len), 72'(exp_len));
      check("rsp_data", rsp_data, exp_data);
      check("wr_strobes", 72'(wr_log.size()), 72'(exp_q.size()));
      nchk = (wr_log.size() < exp_q.size()) ? wr_log.size() : exp_q.size();
      for (int i = 0; i < nchk; i++) begin
         check("wr_byte", 72'(wr_log[i]), 72'(exp_q[i]));
         check("wr_timing", 72'(wr_stamp[i]), 72'(n0 + 2*i));
      end
      check("rd_strobes", 72'(rd_count), 72'(err ? 0 : n_rd));
      check("strobe_rules", 72'(viol), 72'(0));

      if (hold) begin
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_data", rsp_data, exp_data);
            check("hold_ctrl", 72'({rsp_valid, cmd_ready, rsp_err, rsp_len}),
                  72'({1'b1, 1'b0, err, exp_len}));
         end
      end

      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_drop", 72'(rsp_valid), 72'(0));
      check("cmd_ready_rise", 72'(cmd_ready), 72'(1));
   endtask

   // ---------------- stimulus ----------------
   logic [7:0] good_ops [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23};
   logic [7:0] bad_ops  [5] = '{8'h00, 8'h14, 8'h24, 8'h55, 8'hFF};

   initial begin
      int unsigned n0;
      int k;
      logic [7:0] op;

      rst        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_opcode = 8'h00;
      cmd_a      = 24'h0;
      cmd_b      = 24'h0;
      rsp_ready  = 1'b0;
      for (int i = 0; i < 9; i++) dev_bytes[i] = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_outputs", 72'({bus_wr, bus_rd, rsp_valid, rsp_err, cmd_ready, rsp_len, bus_data_out}),
            72'(0));
      check("reset_rsp_data", rsp_data, 72'(0));
      rst = 1'b0;
      @(negedge clk);
      check("cmd_ready_after_reset", 72'(cmd_ready), 72'(1));

      // MULTIPLY: result 0x002000, held off by rsp_ready for 10 cycles
      dev_bytes[0] = 8'h00; dev_bytes[1] = 8'h20; dev_bytes[2] = 8'h00;
      run_txn(8'h20, 24'h001000, 24'h002000, 0, 2, 1'b0, 1'b0, 1'b1);

      // SINCOS: result 0x000000_001000
      dev_bytes[0] = 8'h00; dev_bytes[1] = 8'h10;
      for (int i = 2; i < 6; i++) dev_bytes[i] = 8'h00;
      run_txn(8'h10, 24'h000000, 24'hABCDEF, 1, 3, 1'b0, 1'b0, 1'b0);

      // NORMALIZE: nine bytes 01..09
      for (int i = 0; i < 9; i++) dev_bytes[i] = 8'(i + 1);
      run_txn(8'h13, 24'h003000, 24'h004000, 2, 2, 1'b0, 1'b0, 1'b0);

      // MAC_CLEAR: BUSY high for 2 cycles, no reads
      run_txn(8'h22, 24'h0, 24'h0, 0, 2, 1'b0, 1'b0, 1'b0);

      // Unknown opcode
      run_txn(8'h55, 24'h123456, 24'h654321, 0, 2, 1'b0, 1'b0, 1'b0);

      // BUSY stuck high, then BUSY never rising
      run_txn(8'h22, 24'h0, 24'h0, 0, 2, 1'b1, 1'b0, 1'b0);
      run_txn(8'h20, 24'h111111, 24'h222222, 0, 2, 1'b0, 1'b1, 1'b0);

      // Reset during the low phase of read byte 2
      for (int i = 0; i < 9; i++) dev_bytes[i] = 8'hA1 + 8'(i);
      dev_n_wr = 7; dev_busy_delay = 1; dev_busy_len = 2; dev_forever = 1'b0;
      dev_gen++;
      issue_cmd(8'h13, 24'h0A0B0C, 24'h0D0E0F, n0);
      k = 0;
      while (rd_count != 3 && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("reached_rd_byte2", 72'(rd_count), 72'(3));
      check("rd_low_phase", 72'(bus_rd), 72'(0));
      rst = 1'b1;
      @(negedge clk);
      check("mid_reset_strobes", 72'({bus_wr, bus_rd}), 72'(0));
      check("mid_reset_rsp", 72'({rsp_valid, rsp_err, rsp_len, cmd_ready, bus_data_out}), 72'(0));
      check("mid_reset_data", rsp_data, 72'(0));
      rst = 1'b0;
      @(negedge clk);
      check("cmd_ready_after_mid_reset", 72'(cmd_ready), 72'(1));
      check("rsp_valid_after_mid_reset", 72'(rsp_valid), 72'(0));

      // Randomised transactions
      for (int t = 0; t < 24; t++) begin
         op = ($urandom_range(0, 7) == 0) ? bad_ops[$urandom_range(0, 4)]
                                          : good_ops[$urandom_range(0, 7)];
         for (int i = 0; i < 9; i++) dev_bytes[i] = 8'($urandom);
         run_txn(op, 24'($urandom), 24'($urandom), $urandom_range(0, 3), $urandom_range(2, 5),
                 1'b0, 1'b0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/herald_bus_master.md
Name: herald_bus_master

Overview:
- Host-side initiator for the Herald byte-strobe accelerator bus. It is the other end of the tt_um_herald command/operand/result protocol.
- Accepts one complete command (opcode plus up to two 24-bit Q12.12 operands) on a valid/ready interface, then serialises it onto the 8-bit data bus using WR strobes.
- Polls BUSY, then collects the result bytes using RD strobes and returns them packed on a response interface.
- Used in FPGA/host-side test harnesses and any on-chip controller that drives the Herald CORDIC/MAC unit.

Parameters:
- STROBE_LOW, 1, cycles each strobe is held low after a high cycle. Must be ≥1.
- TIMEOUT, 4096, maximum cycles spent in either BUSY wait state before the transaction is aborted with an error.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE and while rst low
- cmd_opcode  in  8  0x10/11/12/13/20/21/22/23
- cmd_a  in  24  operand A
- cmd_b  in  24  operand B
- rsp_valid  out  1  response valid; held until accepted
- rsp_ready  in  1  response accept
- rsp_data  out  72  result bytes, byte i at [8i+7:8i]; unused bytes zero
- rsp_len  out  4  number of result bytes: 0, 3, 6 or 9
- rsp_err  out  1  1 = unknown opcode or timeout
- bus_data_out  out  8  drives device ui_in
- bus_wr  out  1  drives device uio_in[0]
- bus_rd  out  1  drives device uio_in[1]
- bus_data_in  in  8  from device uo_out; bit 7 = BUSY outside read phases

Behaviour:
- Reset values: all outputs registered and zero (bus_wr=0, bus_rd=0, bus_data_out=0x00, rsp_valid=0, rsp_data=0, rsp_len=0, rsp_err=0). FSM returns to IDLE. Reset mid-transaction abandons the transaction immediately; strobes drop on the next edge.
- Opcode table (writes after the opcode byte / reads):
  - 0x10: A / 6
  - 0x11, 0x12, 0x13, 0x20, 0x21: A+B / 3, except 0x13 reads 9
  - 0x23: A only / 3
  - 0x22: none / 0
- Unknown opcode: no bus activity. One cycle after accept, rsp_valid=1, rsp_err=1, rsp_len=0.
- Accept: cmd_valid&&cmd_ready latches opcode, A and B. cmd_ready drops the next cycle.
- Write sequence: opcode byte, then A[7:0], A[15:8], A[23:16], then B bytes in the same LSB-first order.
- Each byte takes 1 cycle in WR_HI (bus_wr=1, bus_data_out=byte) followed by STROBE_LOW cycles in WR_LO (bus_wr=0, data held). Data is stable the whole time bus_wr is high.
- With default parameters a command+A+B transaction takes 14 cycles from the first WR_HI.
- WAIT_BUSY_HI: after the last WR_LO, wait until bus_data_in[7]=1. This also covers opcode 0x22, where the device shows BUSY for at least 1 cycle.
- WAIT_BUSY_LO: then wait until bus_data_in[7]=0.
- Each wait state has its own counter, cleared on entry. Reaching TIMEOUT gives rsp_err=1, rsp_len=0, and bus strobes stay low.
- If rsp_len=0 (opcode 0x22), go straight to RESP.
- Read sequence, per byte:
  - RD_HI: 1 cycle, bus_rd=1.
  - RD_LO: bus_rd=0. The first RD_LO cycle captures bus_data_in into byte slot k; this is the clock edge two edges after the one asserting bus_rd, and the device holds the byte valid for exactly that cycle.
  - Remaining RD_LO cycles: STROBE_LOW-1. Then the next byte, or RESP after byte rsp_len-1.
- BUSY is not interpreted during reads.
- RESP: rsp_valid=1 with stable rsp_data/rsp_len/rsp_err until rsp_ready. Go to IDLE on the rsp_valid&&rsp_ready cycle. cmd_ready rises the following cycle.
- Never asserts bus_wr and bus_rd together. Never has two consecutive high cycles on either strobe.
- States: IDLE, WR_HI, WR_LO, WAIT_BUSY_HI, WAIT_BUSY_LO, RD_HI, RD_LO, RESP.

Test Plan:
- MULTIPLY 0x20, A=0x001000, B=0x002000, against a cycle-accurate device model:
  - Bus write sequence 20,00,10,00,00,20,00, each byte a 1-high/1-low strobe.
  - Model returns 0x002000, giving rsp_data=0x…002000, rsp_len=3, rsp_err=0.
- SINCOS 0x10, A=0x000000: exactly 4 WR strobes. Model result 0x000000_001000 gives 6 RD strobes, rsp_data[47:0]=0x000000001000, rsp_len=6.
- NORMALIZE 0x13, A=0x003000, B=0x004000:
  - 7 WR strobes, then 9 RD strobes.
  - Model bytes 01..09 give rsp_data=0x090807060504030201, rsp_len=9.
- MAC_CLEAR 0x22: 1 WR strobe, BUSY high 2 cycles then low, 0 RD strobes. Result: rsp_len=0, rsp_err=0.
- Opcode 0x55: no strobes, rsp_err=1 one cycle after accept. Separately, model holding BUSY=1 forever with TIMEOUT=16 gives rsp_err=1 after 16 wait cycles.
- Hold rsp_ready=0 for 10 cycles: rsp outputs stable and cmd_ready=0 throughout. Separately, assert rst during RD_LO of byte 2: strobes low next cycle, rsp_valid=0, cmd_ready=1 after release.
